// File: rtl/stage_memory.sv
// Memory stage: issues lw/sw to a request/ack data memory, stalls upstream while busy, owns the M/W latch.
// Optional bounded wait: define MEM_TIMEOUT_EN to force completion (with exception and sticky dmem_err).
module stage_memory #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_ALU_op,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_ALU_result,
    input  logic [31:0]       in_store_data,
    input  logic [31:0]       in_pc_plus_1,
    input  logic              in_exception,
    output logic              stall,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [31:0]       data_dmem,
    output logic              rden_dmem,
    output logic              wren_dmem,
    input  logic              dmem_ack,
    input  logic [31:0]       q_dmem,
    output logic              out_valid,
    output logic [4:0]        out_opcode,
    output logic [4:0]        out_ALU_op,
    output logic [4:0]        out_rd,
    output logic [31:0]       out_ALU_result,
    output logic [31:0]       out_pc_plus_1,
    output logic [31:0]       out_q_dmem,
    output logic              out_exception,
    output logic              dmem_err
);

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;

    typedef enum logic {RUN, REQ} state_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  aluOp;
        logic [4:0]  rd;
        logic [31:0] aluResult;
        logic [31:0] pcPlus1;
        logic        exception;
    } instr_t;

    if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
        $error("stage_memory: TIMEOUT_CYCLES must be at least 2");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    instr_t            held_q, held_d;
    logic              outValid_q, outValid_d;
    instr_t            outInstr_q, outInstr_d;
    logic [31:0]       outQ_q, outQ_d;
    instr_t            instrIn;
    logic              isLoad;
    logic              isStore;
    logic              timeout;

    assign instrIn = {in_opcode, in_ALU_op, in_rd, in_ALU_result, in_pc_plus_1, in_exception};
    assign isLoad  = (in_opcode == OP_LW);
    assign isStore = (in_opcode == OP_SW);

    // Every cycle the M/W latch takes a bubble unless something completes.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rden_d     = rden_q;
        wren_d     = wren_q;
        held_d     = held_q;
        outValid_d = 1'b0;
        outInstr_d = '0;
        outQ_d     = '0;
        unique case (state_q)
            RUN: begin
                if (in_valid) begin
                    if (isLoad || isStore) begin
                        state_d = REQ;
                        addr_d  = in_ALU_result[ADDR_W-1:0];
                        data_d  = in_store_data;
                        rden_d  = isLoad;
                        wren_d  = isStore;
                        held_d  = instrIn;
                    end else begin
                        outValid_d = 1'b1;
                        outInstr_d = instrIn;
                    end
                end
            end
            REQ: begin
                if (dmem_ack || timeout) begin
                    state_d    = RUN;
                    rden_d     = 1'b0;
                    wren_d     = 1'b0;
                    outValid_d = 1'b1;
                    outInstr_d = held_q;
                    if (dmem_ack && rden_q) begin
                        outQ_d = q_dmem;
                    end
                    if (timeout) begin
                        outInstr_d.exception = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= RUN;
            addr_q     <= '0;
            data_q     <= '0;
            rden_q     <= 1'b0;
            wren_q     <= 1'b0;
            held_q     <= '0;
            outValid_q <= 1'b0;
            outInstr_q <= '0;
            outQ_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rden_q     <= rden_d;
            wren_q     <= wren_d;
            held_q     <= held_d;
            outValid_q <= outValid_d;
            outInstr_q <= outInstr_d;
            outQ_q     <= outQ_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // The counter sits at zero in RUN, so every REQ visit starts fresh; an ack always beats the timeout.
    assign timeout = (state_q == REQ) && !dmem_ack && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        err_d   = err_q | timeout;
        if (state_q == RUN) begin
            count_d = '0;
        end else if (!dmem_ack) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign dmem_err = err_q;
`else
    assign timeout  = 1'b0;
    assign dmem_err = 1'b0;
`endif

    assign stall          = (state_q == REQ);
    assign address_dmem   = addr_q;
    assign data_dmem      = data_q;
    assign rden_dmem      = rden_q;
    assign wren_dmem      = wren_q;
    assign out_valid      = outValid_q;
    assign out_opcode     = outInstr_q.opcode;
    assign out_ALU_op     = outInstr_q.aluOp;
    assign out_rd         = outInstr_q.rd;
    assign out_ALU_result = outInstr_q.aluResult;
    assign out_pc_plus_1  = outInstr_q.pcPlus1;
    assign out_exception  = outInstr_q.exception;
    assign out_q_dmem     = outQ_q;

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: behavioural model compared every cycle plus directed literal checks.
// Honours MEM_TIMEOUT_EN the same way as the design.
module tb_stage_memory;

    localparam int         ADDR_W         = 12;
    localparam int         TIMEOUT_CYCLES = 16;
    localparam logic [4:0] OP_LW          = 5'b01000;
    localparam logic [4:0] OP_SW          = 5'b00111;

    logic              clock;
    logic              reset_n;
    logic              in_valid;
    logic [4:0]        in_opcode;
    logic [4:0]        in_ALU_op;
    logic [4:0]        in_rd;
    logic [31:0]       in_ALU_result;
    logic [31:0]       in_store_data;
    logic [31:0]       in_pc_plus_1;
    logic              in_exception;
    logic              stall;
    logic [ADDR_W-1:0] address_dmem;
    logic [31:0]       data_dmem;
    logic              rden_dmem;
    logic              wren_dmem;
    logic              dmem_ack;
    logic [31:0]       q_dmem;
    logic              out_valid;
    logic [4:0]        out_opcode;
    logic [4:0]        out_ALU_op;
    logic [4:0]        out_rd;
    logic [31:0]       out_ALU_result;
    logic [31:0]       out_pc_plus_1;
    logic [31:0]       out_q_dmem;
    logic              out_exception;
    logic              dmem_err;

    int nCompared   = 0;
    int nMismatched = 0;

    stage_memory #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .in_opcode(in_opcode), .in_ALU_op(in_ALU_op), .in_rd(in_rd),
        .in_ALU_result(in_ALU_result), .in_store_data(in_store_data),
        .in_pc_plus_1(in_pc_plus_1), .in_exception(in_exception),
        .stall(stall), .address_dmem(address_dmem), .data_dmem(data_dmem),
        .rden_dmem(rden_dmem), .wren_dmem(wren_dmem), .dmem_ack(dmem_ack),
        .q_dmem(q_dmem), .out_valid(out_valid), .out_opcode(out_opcode),
        .out_ALU_op(out_ALU_op), .out_rd(out_rd), .out_ALU_result(out_ALU_result),
        .out_pc_plus_1(out_pc_plus_1), .out_q_dmem(out_q_dmem),
        .out_exception(out_exception), .dmem_err(dmem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the stage is either free or busy with one memory instruction; outputs follow from that.
    logic        modelReady = 1'b0;
    logic        busy;
    logic [4:0]  pOp, pAlu, pRd;
    logic [31:0] pRes, pPc;
    logic        pExc;
    logic        eStall, eRden, eWren, eOutValid, eExc, eErr;
    logic [31:0] eAddr, eData, eRes, ePc, eQ;
    logic [4:0]  eOp, eAlu, eRd;
    logic        finished;
    logic        expired;
`ifdef MEM_TIMEOUT_EN
    int          waited;
`endif

    always @(posedge clock) begin
        if (!reset_n) begin
            busy = 1'b0; eStall = 1'b0; eRden = 1'b0; eWren = 1'b0; eAddr = '0; eData = '0;
            eOutValid = 1'b0; eOp = '0; eAlu = '0; eRd = '0; eRes = '0; ePc = '0; eQ = '0;
            eExc = 1'b0; eErr = 1'b0; modelReady = 1'b1;
        end else if (!busy) begin
            eOutValid = 1'b0;
            if (in_valid && (in_opcode == OP_LW || in_opcode == OP_SW)) begin
                busy = 1'b1;
                pOp = in_opcode; pAlu = in_ALU_op; pRd = in_rd; pRes = in_ALU_result;
                pPc = in_pc_plus_1; pExc = in_exception;
                eAddr = {20'd0, in_ALU_result[ADDR_W-1:0]};
                eData = in_store_data;
                eRden = (in_opcode == OP_LW);
                eWren = (in_opcode == OP_SW);
`ifdef MEM_TIMEOUT_EN
                waited = 0;
`endif
            end else if (in_valid) begin
                eOutValid = 1'b1;
                eOp = in_opcode; eAlu = in_ALU_op; eRd = in_rd; eRes = in_ALU_result;
                ePc = in_pc_plus_1; eExc = in_exception; eQ = '0;
            end
        end else begin
            expired = 1'b0;
`ifdef MEM_TIMEOUT_EN
            expired = !dmem_ack && (waited == TIMEOUT_CYCLES - 1);
            waited++;
`endif
            finished = dmem_ack || expired;
            eOutValid = finished;
            if (finished) begin
                busy = 1'b0; eRden = 1'b0; eWren = 1'b0;
                eOp = pOp; eAlu = pAlu; eRd = pRd; eRes = pRes; ePc = pPc;
                eQ = (dmem_ack && pOp == OP_LW) ? q_dmem : 32'd0;
                eExc = pExc | expired;
                if (expired) eErr = 1'b1;
            end
        end
        eStall = busy;
    end

    always @(negedge clock) begin
        if (modelReady) begin
            checkOutput("stall", 32'(stall), 32'(eStall));
            checkOutput("address_dmem", 32'(address_dmem), eAddr);
            checkOutput("data_dmem", data_dmem, eData);
            checkOutput("rden_dmem", 32'(rden_dmem), 32'(eRden));
            checkOutput("wren_dmem", 32'(wren_dmem), 32'(eWren));
            checkOutput("out_valid", 32'(out_valid), 32'(eOutValid));
            checkOutput("dmem_err", 32'(dmem_err), 32'(eErr));
            if (eOutValid) begin
                checkOutput("out_opcode", 32'(out_opcode), 32'(eOp));
                checkOutput("out_ALU_op", 32'(out_ALU_op), 32'(eAlu));
                checkOutput("out_rd", 32'(out_rd), 32'(eRd));
                checkOutput("out_ALU_result", out_ALU_result, eRes);
                checkOutput("out_pc_plus_1", out_pc_plus_1, ePc);
                checkOutput("out_q_dmem", out_q_dmem, eQ);
                checkOutput("out_exception", 32'(out_exception), 32'(eExc));
            end
        end
    end

    // Presents one instruction; for memory ops holds it and raises ack in REQ cycle ackAfter (0 = never).
    task automatic applyStimulus(input logic [4:0] op, input logic [4:0] aluOp, input logic [4:0] rd,
                                 input logic [31:0] res, input logic [31:0] store, input logic [31:0] pc,
                                 input logic exc, input int ackAfter, input logic [31:0] qData,
                                 output int stallCycles, output int strobeCycles,
                                 output logic [31:0] firstAddr, output logic [31:0] firstData);
        int waitCycles;
        in_valid = 1'b1; in_opcode = op; in_ALU_op = aluOp; in_rd = rd; in_ALU_result = res;
        in_store_data = store; in_pc_plus_1 = pc; in_exception = exc;
        stallCycles = 0;
        strobeCycles = 0;
        @(posedge clock); #1;
        firstAddr = 32'(address_dmem);
        firstData = data_dmem;
        if (op == OP_LW || op == OP_SW) begin
            waitCycles = (ackAfter == 0) ? TIMEOUT_CYCLES : ackAfter;
            for (int i = 1; i <= waitCycles; i++) begin
                if (stall) stallCycles++;
                if (rden_dmem || wren_dmem) strobeCycles++;
                dmem_ack = (i == ackAfter);
                q_dmem   = (i == ackAfter) ? qData : (32'hBAD0_0000 + 32'(i));
                @(posedge clock); #1;
            end
            dmem_ack = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    int          sc, stc;
    logic [31:0] fa, fd;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_ALU_op = '0; in_rd = '0;
        in_ALU_result = '0; in_store_data = '0; in_pc_plus_1 = '0; in_exception = 1'b0;
        dmem_ack = 1'b0; q_dmem = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset rden", 32'(rden_dmem), 32'd0);
        checkOutput("reset wren", 32'(wren_dmem), 32'd0);
        checkOutput("reset address", 32'(address_dmem), 32'd0);
        checkOutput("reset data", data_dmem, 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_ALU_result", out_ALU_result, 32'd0);
        checkOutput("reset out_q_dmem", out_q_dmem, 32'd0);
        checkOutput("reset dmem_err", 32'(dmem_err), 32'd0);
        reset_n = 1'b1;
        idle(1);

        $display("[TB] add, single-cycle latency");
        applyStimulus(5'd0, 5'd0, 5'd3, 32'h1234, 32'h0, 32'h11, 1'b0, 0, 32'h0, sc, stc, fa, fd);
        checkOutput("add out_valid", 32'(out_valid), 32'd1);
        checkOutput("add out_ALU_result", out_ALU_result, 32'h1234);
        checkOutput("add out_q_dmem", out_q_dmem, 32'h0);
        checkOutput("add stall", 32'(stall), 32'd0);

        $display("[TB] non-memory op with exception and stray ack in RUN");
        dmem_ack = 1'b1; q_dmem = 32'hFFFF_FFFF;
        applyStimulus(5'd1, 5'd2, 5'd4, 32'h8000_0000, 32'h0, 32'h12, 1'b1, 0, 32'h0, sc, stc, fa, fd);
        dmem_ack = 1'b0;
        checkOutput("exc out_exception", 32'(out_exception), 32'd1);
        checkOutput("exc out_q_dmem", out_q_dmem, 32'h0);
        checkOutput("exc stall", 32'(stall), 32'd0);
        idle(1);

        $display("[TB] lw acked after 3 cycles");
        applyStimulus(OP_LW, 5'd0, 5'd5, 32'h0000_0ABC, 32'h0, 32'h20, 1'b0, 3, 32'hDEAD_BEEF, sc, stc, fa, fd);
        checkOutput("lw address", fa, 32'hABC);
        checkOutput("lw stall cycles", 32'(sc), 32'd3);
        checkOutput("lw rden cycles", 32'(stc), 32'd3);
        checkOutput("lw out_valid", 32'(out_valid), 32'd1);
        checkOutput("lw out_q_dmem", out_q_dmem, 32'hDEAD_BEEF);
        checkOutput("lw rden after ack", 32'(rden_dmem), 32'd0);
        idle(1);
        checkOutput("lw out_valid one cycle", 32'(out_valid), 32'd0);

        $display("[TB] sw acked in first REQ cycle");
        applyStimulus(OP_SW, 5'd0, 5'd0, 32'h010, 32'h55AA_55AA, 32'h30, 1'b0, 1, 32'h1234_5678, sc, stc, fa, fd);
        checkOutput("sw address", fa, 32'h010);
        checkOutput("sw data", fd, 32'h55AA_55AA);
        checkOutput("sw wren cycles", 32'(stc), 32'd1);
        checkOutput("sw out_valid", 32'(out_valid), 32'd1);
        checkOutput("sw out_q_dmem", out_q_dmem, 32'h0);
        idle(2);

        $display("[TB] lw then lw back-to-back");
        applyStimulus(OP_LW, 5'd0, 5'd6, 32'h7000_0100, 32'h0, 32'h40, 1'b0, 2, 32'hCAFE_0001, sc, stc, fa, fd);
        checkOutput("lw1 bubbles", 32'(sc), 32'd2);
        checkOutput("lw1 out_q_dmem", out_q_dmem, 32'hCAFE_0001);
        checkOutput("lw1 out_ALU_result", out_ALU_result, 32'h7000_0100);
        checkOutput("lw1 address held", 32'(address_dmem), 32'h100);
        applyStimulus(OP_LW, 5'd0, 5'd7, 32'h200, 32'h0, 32'h41, 1'b0, 2, 32'h0BAD_F00D, sc, stc, fa, fd);
        checkOutput("lw2 address next cycle", fa, 32'h200);
        checkOutput("lw2 bubbles", 32'(sc), 32'd2);
        checkOutput("lw2 out_q_dmem", out_q_dmem, 32'h0BAD_F00D);
        checkOutput("lw2 out_rd", 32'(out_rd), 32'd7);
        idle(1);

        $display("[TB] reset during REQ, stray ack afterwards");
        in_valid = 1'b1; in_opcode = OP_LW; in_rd = 5'd8; in_ALU_result = 32'h300; in_exception = 1'b0;
        @(posedge clock); #1;
        checkOutput("req stall before reset", 32'(stall), 32'd1);
        reset_n = 1'b0; in_valid = 1'b0;
        @(posedge clock); #1;
        checkOutput("rst stall", 32'(stall), 32'd0);
        checkOutput("rst rden", 32'(rden_dmem), 32'd0);
        checkOutput("rst address", 32'(address_dmem), 32'd0);
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        dmem_ack = 1'b1; q_dmem = 32'h1111_1111;
        @(posedge clock); #1;
        dmem_ack = 1'b0;
        checkOutput("stray ack out_valid", 32'(out_valid), 32'd0);
        checkOutput("stray ack stall", 32'(stall), 32'd0);
        idle(1);

`ifdef MEM_TIMEOUT_EN
        $display("[TB] lw never acked, timeout");
        applyStimulus(OP_LW, 5'd0, 5'd9, 32'h40, 32'h0, 32'h50, 1'b0, 0, 32'h0, sc, stc, fa, fd);
        checkOutput("to stall cycles", 32'(sc), 32'd16);
        checkOutput("to out_valid", 32'(out_valid), 32'd1);
        checkOutput("to out_exception", 32'(out_exception), 32'd1);
        checkOutput("to out_q_dmem", out_q_dmem, 32'h0);
        checkOutput("to dmem_err", 32'(dmem_err), 32'd1);
        idle(3);
        checkOutput("to dmem_err sticky", 32'(dmem_err), 32'd1);
        applyStimulus(OP_LW, 5'd0, 5'd10, 32'h44, 32'h0, 32'h51, 1'b0, 16, 32'h600D_600D, sc, stc, fa, fd);
        checkOutput("ack beats timeout exception", 32'(out_exception), 32'd0);
        checkOutput("ack beats timeout data", out_q_dmem, 32'h600D_600D);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        checkOutput("to dmem_err cleared", 32'(dmem_err), 32'd0);
`else
        $display("[TB] lw with long wait, no timeout");
        applyStimulus(OP_LW, 5'd0, 5'd9, 32'h40, 32'h0, 32'h50, 1'b0, 20, 32'h600D_600D, sc, stc, fa, fd);
        checkOutput("long wait stall cycles", 32'(sc), 32'd20);
        checkOutput("long wait out_q_dmem", out_q_dmem, 32'h600D_600D);
        checkOutput("long wait out_exception", 32'(out_exception), 32'd0);
        checkOutput("long wait dmem_err", 32'(dmem_err), 32'd0);
`endif
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
